udp_tx_arbiter: RTL and testbench
=================================

Name: udp_tx_arbiter

Overview:
- Packet-level round-robin arbiter sharing the single UDP transmit user port (10-bit {sop, eop, data} beats) between N_REQ packet sources, e.g. application, ICMP echo and a debug streamer.
- Grants one whole packet (sop..eop) at a time and respects transmit-FIFO back-pressure.
- Enforces the 1472-byte UDP payload limit by truncation.
- Sits directly in front of the UDP block's u_din/u_din_vld inputs.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_LEN, 1472, maximum payload beats per forwarded packet.
- CNT_W, 16, width of packet statistics counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- req_vld  in  N_REQ  per-requester beat valid.
- req_data  in  N_REQ*10  per-requester beat, slice i = [10i+9:10i]; bit9 sop, bit8 eop, [7:0] byte.
- req_rdy  out  N_REQ  per-requester beat accepted (combinational).
- out_full  in  1  transmit data FIFO or length FIFO cannot take 2 more beats; drive from u_status[25] | u_status[24] through a programmable-full threshold.
- out_vld  out  1  to u_din_vld.
- out_data  out  10  to u_din.
- grant  out  N_REQ  one-hot current owner; 0 in IDLE.
- pkt_cnt  out  CNT_W  packets forwarded, including truncated ones; wraps.
- trunc_cnt  out  8  truncated packets; saturates at 255.
- drop_cnt  out  8  orphan beats discarded; saturates at 255.

Behaviour:
- Reset: state=IDLE, rr pointer=N_REQ-1 (channel 0 has first priority), grant=0, out_vld=0, out_data=0, all counters=0, beat counter=0. Reset mid-packet abandons the packet with no eop emitted.
- A beat transfers on channel i when req_vld[i] & req_rdy[i].
- out_vld/out_data are registered: a beat accepted in cycle t appears in cycle t+1. out_vld is 0 in every cycle with no transfer.
- State IDLE:
  - Every channel whose head beat has sop=0 gets rdy=1; its beat is discarded and drop_cnt increments once per cycle with any such discard.
  - Among channels with vld & sop, select the first after the rr pointer (circular).
  - Register grant, set the pointer to the winner, clear the beat counter, go to XFER.
  - No beat of the winner is accepted in the decision cycle, so arbitration costs 1 cycle.
- State XFER:
  - req_rdy[g] = !out_full; all other rdy=0.
  - On each transfer, beat counter++. Forwarded sop = (counter==0). Forwarded eop = in_eop | (counter==MAX_LEN-1).
  - In-packet sop bits after the first beat are cleared.
  - Requester eop on the transfer: pkt_cnt++, grant=0, go to IDLE.
  - Forced eop without requester eop: pkt_cnt++, trunc_cnt++, go to FLUSH.
  - A requester eop exactly on beat MAX_LEN is not a truncation.
  - A single-beat packet (sop&eop) is forwarded with both bits set.
- State FLUSH:
  - req_rdy[g]=1 regardless of out_full; beats are discarded with out_vld=0.
  - On the requester's eop go to IDLE with grant=0.
- out_full is sampled only for rdy; a beat already registered is always presented, so the FIFO needs 2 slots of margin.
- Counters: pkt_cnt wraps modulo 2^CNT_W; trunc_cnt and drop_cnt saturate.
- Simultaneous events: sop requests on several channels resolve by the rr pointer. IDLE discards of other channels coincide with arbitration.

Decomposition:
- Shared package udp_pkg: beat field constants SOP_BIT=9, EOP_BIT=8, DATA_MSB=7; UDP_MAX_PAYLOAD=1472; state encoding IDLE/XFER/FLUSH.
- One sub-module, rr_picker: combinational circular priority select of an N-bit request vector from a pointer, returning a one-hot result and a valid flag. The FSM, datapath and counters stay in the top level.

Test Plan:
- Ch0 sends 3-beat packet (sop on 0x11, then 0x22, eop on 0x33), out_full=0 -> out_data 0x211,0x022,0x133 on consecutive cycles, first output 2 cycles after req_vld; pkt_cnt=1.
- Ch0 and ch2 both request a 4-beat packet every time they return to IDLE, for 4 packets -> grant order 0,2,0,2; no interleaving of beats; pkt_cnt=4.
- Ch1 sends a 1500-beat packet -> 1472 beats forwarded, beat 1472 carries eop, remaining 28 consumed with out_vld=0; trunc_cnt=1. A 1472-beat packet gives trunc_cnt unchanged.
- out_full asserted for 5 cycles mid-packet -> req_rdy[g]=0 exactly those cycles, no beat lost or duplicated, output sequence intact.
- Ch3 presents 3 beats with sop=0 while idle -> all accepted and discarded, drop_cnt=3, no output. Then a valid packet is forwarded normally.
- rst driven low asynchronously mid-XFER -> out_vld, grant and counters go to 0 immediately; after release, ch0 wins first arbitration.

Source files
------------

// File: rtl/udp_pkg.sv
// udp_pkg: beat layout, payload limit and arbiter state
// encoding shared by the UDP transmit path.
package udp_pkg;

    localparam int BEAT_W          = 10;
    localparam int SOP_BIT         = 9;
    localparam int EOP_BIT         = 8;
    localparam int DATA_MSB        = 7;
    localparam int UDP_MAX_PAYLOAD = 1472;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/udp_tx_arbiter_rr_picker.sv
// rr_picker: circular priority select, first request after ptr.
// Ports: req (requests), ptr (last winner), gnt (one-hot), vld.
module rr_picker #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    logic [PW-1:0] sel;

    always_comb begin
        gnt = '0;
        sel = '0;
        for (int k = 1; k <= N; k++) begin
            sel = PW'((int'(ptr) + k) % N);
            if (gnt == '0 && req[sel])
                gnt[sel] = 1'b1;
        end
    end

    assign vld = |req;

endmodule

// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: packet round-robin arbiter for the UDP tx port.
// Ports: clk, rst (async low); req_vld/req_data/req_rdy per source;
// out_full back-pressure; out_vld/out_data registered beat;
// grant one-hot owner; pkt_cnt, trunc_cnt, drop_cnt statistics.
module udp_tx_arbiter
    import udp_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int MAX_LEN = UDP_MAX_PAYLOAD,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_vld,
    input  logic [N_REQ*BEAT_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_rdy,
    input  logic                    out_full,
    output logic                    out_vld,
    output logic [BEAT_W-1:0]       out_data,
    output logic [N_REQ-1:0]        grant,
    output logic [CNT_W-1:0]        pkt_cnt,
    output logic [7:0]              trunc_cnt,
    output logic [7:0]              drop_cnt
);

    localparam int PW = $clog2(N_REQ);
    localparam int BW = $clog2(MAX_LEN + 1);

    arb_state_t state, state_nxt;

    logic [PW-1:0]      ptr;
    logic [PW-1:0]      pick_idx;
    logic [BW-1:0]      beat_cnt;
    logic [N_REQ-1:0]   head_sop;
    logic [N_REQ-1:0]   pick_gnt;
    logic               pick_vld;
    logic [DATA_MSB:0]  g_data;
    logic               g_eop;
    logic               g_vld;
    logic               drop_any;
    logic               xfer;
    logic               last_beat;
    logic               flush_end;

    always_comb begin
        head_sop = '0;
        g_data   = '0;
        g_eop    = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            head_sop[i] = req_data[BEAT_W*i+SOP_BIT];
            if (grant[i]) begin
                g_eop  = req_data[BEAT_W*i+EOP_BIT];
                g_data = req_data[BEAT_W*i +: DATA_MSB+1];
            end
        end
    end

    rr_picker #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req (req_vld & head_sop),
        .ptr (ptr),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++)
            if (pick_gnt[i]) pick_idx = PW'(i);
    end

    assign drop_any  = |(req_vld & ~head_sop);
    assign g_vld     = |(req_vld & grant);
    assign xfer      = (state == XFER) && g_vld && !out_full;
    assign last_beat = (beat_cnt == BW'(MAX_LEN - 1));
    assign flush_end = (state == FLUSH) && g_vld && g_eop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (pick_vld) state_nxt = XFER;
            end
            XFER: begin
                if (xfer && g_eop)
                    state_nxt = IDLE;
                else if (xfer && last_beat)
                    state_nxt = FLUSH;
            end
            FLUSH: begin
                if (flush_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Idle accepts orphan (non-sop) heads so they cannot block a port;
    // flush drains the tail of a truncated packet even when full.
    always_comb begin
        req_rdy = '0;
        unique case (state)
            IDLE:    req_rdy = ~head_sop;
            XFER:    req_rdy = out_full ? '0 : grant;
            FLUSH:   req_rdy = grant;
            default: req_rdy = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr       <= PW'(N_REQ - 1);
            grant     <= '0;
            beat_cnt  <= '0;
            out_vld   <= 1'b0;
            out_data  <= '0;
            pkt_cnt   <= '0;
            trunc_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            out_vld <= xfer;
            if (state == IDLE) begin
                if (drop_any && drop_cnt != 8'hFF)
                    drop_cnt <= drop_cnt + 8'd1;
                if (pick_vld) begin
                    grant    <= pick_gnt;
                    ptr      <= pick_idx;
                    beat_cnt <= '0;
                end
            end
            if (xfer) begin
                out_data <= {beat_cnt == '0,
                             g_eop | last_beat,
                             g_data};
                beat_cnt <= beat_cnt + 1'b1;
                if (g_eop || last_beat)
                    pkt_cnt <= pkt_cnt + 1'b1;
                if (g_eop)
                    grant <= '0;
                else if (last_beat && trunc_cnt != 8'hFF)
                    trunc_cnt <= trunc_cnt + 8'd1;
            end
            if (flush_end)
                grant <= '0;
        end
    end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// tb_udp_tx_arbiter: directed scenarios for udp_tx_arbiter.
// Queue-fed sources, negedge output monitor, inline checks.
module tb_udp_tx_arbiter;

    localparam int N = 4;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req_vld;
    logic [N*10-1:0] req_data;
    logic [N-1:0]  req_rdy;
    logic          out_full;
    logic          out_vld;
    logic [9:0]    out_data;
    logic [N-1:0]  grant;
    logic [15:0]   pkt_cnt;
    logic [7:0]    trunc_cnt;
    logic [7:0]    drop_cnt;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [9:0]   src_q [N][$];
    logic [9:0]   out_q [$];
    int           out_cyc [$];
    logic [N-1:0] glog [$];
    logic [N-1:0] prev_g = '0;

    udp_tx_arbiter #(
        .N_REQ   (N),
        .MAX_LEN (1472),
        .CNT_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_vld   (req_vld),
        .req_data  (req_data),
        .req_rdy   (req_rdy),
        .out_full  (out_full),
        .out_vld   (out_vld),
        .out_data  (out_data),
        .grant     (grant),
        .pkt_cnt   (pkt_cnt),
        .trunc_cnt (trunc_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst && out_vld) begin
            out_q.push_back(out_data);
            out_cyc.push_back(cyc);
        end
        if (grant !== prev_g && grant != '0)
            glog.push_back(grant);
        prev_g = grant;
    end

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                req_vld[i] = 1'b1;
                req_data[10*i +: 10] = src_q[i][0];
            end else begin
                req_vld[i] = 1'b0;
                req_data[10*i +: 10] = '0;
            end
        end
    endtask

    initial begin : src_drv
        logic [N-1:0] f;
        forever begin
            @(negedge clk);
            f = req_vld & req_rdy;
            @(posedge clk);
            #1;
            if (!rst) f = '0;
            for (int i = 0; i < N; i++)
                if (f[i] && src_q[i].size() > 0)
                    void'(src_q[i].pop_front());
            drive_inputs();
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        out_q.delete();
        out_cyc.delete();
        glog.delete();
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        bit busy;
        done = 1'b0;
        for (int n = 0; n < budget && !done; n++) begin
            busy = (grant != '0) || out_vld;
            for (int i = 0; i < N; i++)
                if (src_q[i].size() > 0) busy = 1'b1;
            if (!busy) done = 1'b1;
            else       step(1);
        end
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL wait_idle: still busy after %0d cycles",
                     budget);
        end
    endtask

    task automatic test_reset();
        step(2);
        tests += 6;
        if (out_vld !== 1'b0) begin fails++;
            $display("FAIL rst_out_vld: got %b want 0", out_vld); end
        if (out_data !== 10'h000) begin fails++;
            $display("FAIL rst_out_data: got %h want 000", out_data); end
        if (grant !== 4'b0000) begin fails++;
            $display("FAIL rst_grant: got %b want 0000", grant); end
        if (pkt_cnt !== 16'd0) begin fails++;
            $display("FAIL rst_pkt: got %0d want 0", pkt_cnt); end
        if (trunc_cnt !== 8'd0) begin fails++;
            $display("FAIL rst_trunc: got %0d want 0", trunc_cnt); end
        if (drop_cnt !== 8'd0) begin fails++;
            $display("FAIL rst_drop: got %0d want 0", drop_cnt); end
        rst = 1'b1;
        step(2);
        tests++;
        if (out_vld !== 1'b0) begin fails++;
            $display("FAIL rst_idle_vld: got %b want 0", out_vld); end
    endtask

    task automatic test_single();
        logic [9:0] exp_b [3];
        int k;
        exp_b = '{10'h211, 10'h022, 10'h133};
        clear_logs();
        k = cyc;
        src_q[0].push_back(10'h211);
        src_q[0].push_back(10'h022);
        src_q[0].push_back(10'h133);
        drive_inputs();
        wait_idle(50);
        tests++;
        if (out_q.size() != 3) begin fails++;
            $display("FAIL single_len: got %0d want 3", out_q.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                tests++;
                if (out_q[j] !== exp_b[j]) begin fails++;
                    $display("FAIL single_beat%0d: got %h want %h",
                             j, out_q[j], exp_b[j]);
                end
            end
            tests += 2;
            if (out_cyc[0] != k + 2) begin fails++;
                $display("FAIL single_lat: got cyc %0d want %0d",
                         out_cyc[0], k + 2); end
            if (out_cyc[2] != k + 4) begin fails++;
                $display("FAIL single_consec: got cyc %0d want %0d",
                         out_cyc[2], k + 4); end
        end
        tests++;
        if (pkt_cnt !== 16'd1) begin fails++;
            $display("FAIL single_pkt: got %0d want 1", pkt_cnt); end
    endtask

    task automatic test_rr();
        logic [7:0] bases [4];
        logic [9:0] e;
        int bad;
        bases = '{8'h00, 8'h80, 8'h10, 8'h90};
        rst = 1'b0;
        step(1);
        rst = 1'b1;
        step(1);
        clear_logs();
        for (int b = 0; b < 4; b++) begin
            src_q[0].push_back({b == 0, b == 3, 8'h00 + 8'(b)});
            src_q[2].push_back({b == 0, b == 3, 8'h80 + 8'(b)});
        end
        for (int b = 0; b < 4; b++) begin
            src_q[0].push_back({b == 0, b == 3, 8'h10 + 8'(b)});
            src_q[2].push_back({b == 0, b == 3, 8'h90 + 8'(b)});
        end
        drive_inputs();
        wait_idle(100);
        tests++;
        if (glog.size() != 4) begin fails++;
            $display("FAIL rr_ngrant: got %0d want 4", glog.size());
        end else begin
            tests++;
            if (glog[0] !== 4'b0001 || glog[1] !== 4'b0100 ||
                glog[2] !== 4'b0001 || glog[3] !== 4'b0100) begin
                fails++;
                $display("FAIL rr_order: got %b %b %b %b want 0001 0100 0001 0100",
                         glog[0], glog[1], glog[2], glog[3]);
            end
        end
        tests++;
        if (out_q.size() != 16) begin fails++;
            $display("FAIL rr_len: got %0d want 16", out_q.size());
        end else begin
            bad = -1;
            for (int j = 0; j < 16; j++) begin
                e = {j % 4 == 0, j % 4 == 3, bases[j/4] + 8'(j % 4)};
                if (bad < 0 && out_q[j] !== e) bad = j;
            end
            tests++;
            if (bad >= 0) begin fails++;
                $display("FAIL rr_seq: beat %0d got %h want %h", bad,
                    out_q[bad],
                    {bad % 4 == 0, bad % 4 == 3, bases[bad/4] + 8'(bad % 4)});
            end
        end
        tests++;
        if (pkt_cnt !== 16'd4) begin fails++;
            $display("FAIL rr_pkt: got %0d want 4", pkt_cnt); end
    endtask

    task automatic test_trunc();
        int bad;
        clear_logs();
        for (int k = 0; k < 1500; k++)
            src_q[1].push_back({k == 0, k == 1499, k[7:0]});
        drive_inputs();
        wait_idle(2000);
        tests++;
        if (out_q.size() != 1472) begin fails++;
            $display("FAIL trunc_len: got %0d want 1472", out_q.size());
        end else begin
            bad = -1;
            for (int j = 0; j < 1472; j++)
                if (bad < 0 && out_q[j] !== {j == 0, j == 1471, j[7:0]})
                    bad = j;
            tests++;
            if (bad >= 0) begin fails++;
                $display("FAIL trunc_seq: beat %0d got %h want %h", bad,
                    out_q[bad], {bad == 0, bad == 1471, bad[7:0]});
            end
        end
        tests += 3;
        if (src_q[1].size() != 0) begin fails++;
            $display("FAIL trunc_flush: got %0d left want 0",
                     src_q[1].size()); end
        if (trunc_cnt !== 8'd1) begin fails++;
            $display("FAIL trunc_cnt: got %0d want 1", trunc_cnt); end
        if (pkt_cnt !== 16'd5) begin fails++;
            $display("FAIL trunc_pkt: got %0d want 5", pkt_cnt); end

        clear_logs();
        for (int k = 0; k < 1472; k++)
            src_q[1].push_back({k == 0, k == 1471, k[7:0]});
        drive_inputs();
        wait_idle(2000);
        tests += 4;
        if (out_q.size() != 1472) begin fails++;
            $display("FAIL exact_len: got %0d want 1472", out_q.size()); end
        else if (out_q[1471] !== 10'h1BF) begin fails++;
            $display("FAIL exact_last: got %h want 1bf", out_q[1471]); end
        if (trunc_cnt !== 8'd1) begin fails++;
            $display("FAIL exact_trunc: got %0d want 1", trunc_cnt); end
        if (pkt_cnt !== 16'd6) begin fails++;
            $display("FAIL exact_pkt: got %0d want 6", pkt_cnt); end
        if (out_q.size() > 0 && out_q[0] !== 10'h200) begin fails++;
            $display("FAIL exact_first: got %h want 200", out_q[0]); end
    endtask

    task automatic test_backpressure();
        int bad;
        clear_logs();
        for (int b = 0; b < 10; b++)
            src_q[0].push_back({b == 0, b == 9, 8'h40 + 8'(b)});
        drive_inputs();
        step(3);
        out_full = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            tests++;
            if (req_rdy[0] !== 1'b0 || grant !== 4'b0001) begin fails++;
                $display("FAIL bp_rdy%0d: got rdy %b grant %b want 0 0001",
                         n, req_rdy[0], grant); end
            if (n > 0) begin
                tests++;
                if (out_vld !== 1'b0) begin fails++;
                    $display("FAIL bp_vld%0d: got %b want 0", n, out_vld);
                end
            end
            step(1);
        end
        out_full = 1'b0;
        @(negedge clk);
        tests++;
        if (req_rdy[0] !== 1'b1) begin fails++;
            $display("FAIL bp_resume: got %b want 1", req_rdy[0]); end
        step(1);
        wait_idle(60);
        tests++;
        if (out_q.size() != 10) begin fails++;
            $display("FAIL bp_len: got %0d want 10", out_q.size());
        end else begin
            bad = -1;
            for (int j = 0; j < 10; j++)
                if (bad < 0 &&
                    out_q[j] !== {j == 0, j == 9, 8'h40 + 8'(j)})
                    bad = j;
            tests++;
            if (bad >= 0) begin fails++;
                $display("FAIL bp_seq: beat %0d got %h", bad, out_q[bad]);
            end
        end
        tests++;
        if (pkt_cnt !== 16'd7) begin fails++;
            $display("FAIL bp_pkt: got %0d want 7", pkt_cnt); end
    endtask

    task automatic test_drop();
        clear_logs();
        src_q[3].push_back(10'h001);
        src_q[3].push_back(10'h002);
        src_q[3].push_back(10'h103);
        drive_inputs();
        wait_idle(20);
        tests += 3;
        if (drop_cnt !== 8'd3) begin fails++;
            $display("FAIL drop_cnt: got %0d want 3", drop_cnt); end
        if (out_q.size() != 0) begin fails++;
            $display("FAIL drop_out: got %0d beats want 0", out_q.size()); end
        if (glog.size() != 0) begin fails++;
            $display("FAIL drop_grant: got %0d grants want 0", glog.size()); end
        clear_logs();
        src_q[3].push_back(10'h2C0);
        src_q[3].push_back(10'h0C1);
        src_q[3].push_back(10'h1C2);
        drive_inputs();
        wait_idle(30);
        tests += 3;
        if (out_q.size() != 3 || out_q[0] !== 10'h2C0 ||
            out_q[1] !== 10'h0C1 || out_q[2] !== 10'h1C2) begin fails++;
            $display("FAIL drop_next: got %0d beats first %h want 3 beats 2c0",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 10'h0);
        end
        if (pkt_cnt !== 16'd8) begin fails++;
            $display("FAIL drop_pkt: got %0d want 8", pkt_cnt); end
        if (glog.size() != 1 || glog[0] !== 4'b1000) begin fails++;
            $display("FAIL drop_owner: got %0d grants want 1 of 1000",
                     glog.size()); end
    endtask

    task automatic test_async_reset();
        clear_logs();
        for (int b = 0; b < 20; b++)
            src_q[0].push_back({b == 0, b == 19, 8'h50 + 8'(b)});
        drive_inputs();
        step(5);
        tests += 2;
        if (out_vld !== 1'b1) begin fails++;
            $display("FAIL ar_pre_vld: got %b want 1", out_vld); end
        if (grant !== 4'b0001) begin fails++;
            $display("FAIL ar_pre_grant: got %b want 0001", grant); end
        rst = 1'b0;
        #1;
        tests += 5;
        if (out_vld !== 1'b0) begin fails++;
            $display("FAIL ar_vld: got %b want 0", out_vld); end
        if (grant !== 4'b0000) begin fails++;
            $display("FAIL ar_grant: got %b want 0000", grant); end
        if (pkt_cnt !== 16'd0) begin fails++;
            $display("FAIL ar_pkt: got %0d want 0", pkt_cnt); end
        if (trunc_cnt !== 8'd0) begin fails++;
            $display("FAIL ar_trunc: got %0d want 0", trunc_cnt); end
        if (drop_cnt !== 8'd0) begin fails++;
            $display("FAIL ar_drop: got %0d want 0", drop_cnt); end
        for (int i = 0; i < N; i++) src_q[i].delete();
        drive_inputs();
        step(2);
        rst = 1'b1;
        step(1);
        clear_logs();
        src_q[1].push_back(10'h2A1);
        src_q[1].push_back(10'h1A2);
        src_q[0].push_back(10'h2B1);
        src_q[0].push_back(10'h1B2);
        drive_inputs();
        wait_idle(30);
        tests += 3;
        if (glog.size() != 2 || glog[0] !== 4'b0001 ||
            glog[1] !== 4'b0010) begin fails++;
            $display("FAIL ar_first: got %0d grants first %b want 0001 then 0010",
                     glog.size(), glog.size() > 0 ? glog[0] : 4'b0);
        end
        if (out_q.size() != 4 || out_q[0] !== 10'h2B1 ||
            out_q[1] !== 10'h1B2 || out_q[2] !== 10'h2A1 ||
            out_q[3] !== 10'h1A2) begin fails++;
            $display("FAIL ar_seq: got %0d beats first %h want 2b1 1b2 2a1 1a2",
                     out_q.size(), out_q.size() > 0 ? out_q[0] : 10'h0);
        end
        if (pkt_cnt !== 16'd2) begin fails++;
            $display("FAIL ar_pkt_after: got %0d want 2", pkt_cnt); end
    endtask

    initial begin
        rst      = 1'b0;
        out_full = 1'b0;
        req_vld  = '0;
        req_data = '0;
        test_reset();
        test_single();
        test_rr();
        test_trunc();
        test_backpressure();
        test_drop();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
